// File: rtl/reg_arb_pkg.sv
// Shared types and default sizes for the two-requester register-bank arbiter.
// Pure declarations: no logic, no latency, no flow control.
package reg_arb_pkg;

  localparam int unsigned NREGS_DEF = 8;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned AW_DEF    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Requester 0 or requester 1.
  typedef logic req_id_t;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bus of the arbiter: two request ports, one-hot grant/response.
// Grant is combinational in IDLE; response returns two cycles after grant.
interface reg_bank_arbiter_if #(
  parameter int unsigned DW = reg_arb_pkg::DW_DEF,
  parameter int unsigned AW = reg_arb_pkg::AW_DEF
);
  logic [1:0]         req_i;
  logic [1:0][AW-1:0] addr_i;
  logic [1:0]         we_i;
  logic [1:0][DW-1:0] wdata_i;
  logic [1:0]         gnt_o;
  logic [1:0]         rvalid_o;
  logic [DW-1:0]      rdata_o;
  logic               err_o;

  modport master (
    output req_i, addr_i, we_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the side not granted last.
// Purely combinational; the caller owns the last-grant state.
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Serialises two requesters onto a bank of NREGS subregisters: grant in IDLE, pulse in ACCESS, respond in RESP.
// Grant-to-rvalid is 2 cycles; requests arriving while busy simply wait (no grant) until the next IDLE.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  reg_bank_arbiter_if.slave         bus,
  output logic [NREGS-1:0]          reg_we_o,
  output logic [NREGS-1:0]          reg_re_o,
  output logic [DW-1:0]             reg_wd_o,
  input  logic [NREGS-1:0][DW-1:0]  reg_qs_i
);

  localparam int unsigned IW = AW - 2;

  state_e        state_q, state_d;
  req_id_t       owner_q, last_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic          err_q;

  logic [1:0]       arb_gnt;
  logic [IW-1:0]    idx;
  logic [NREGS-1:0] idx_oh;
  logic [DW-1:0]    qs_sel;
  logic             dec_err;

  rr_arb2 u_rr_arb2 (
    .req_i  (bus.req_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  assign idx = addr_q[AW-1:2];

  // Loop-based decode keeps out-of-range indices from ever selecting a register.
  always_comb begin
    idx_oh = '0;
    qs_sel = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (32'(idx) == i) begin
        idx_oh[i] = 1'b1;
        qs_sel    = reg_qs_i[i];
      end
    end
    dec_err = (addr_q[1:0] != 2'b00) || (32'(idx) >= NREGS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.gnt_o    = '0;
    bus.rvalid_o = '0;
    bus.rdata_o  = '0;
    bus.err_o    = 1'b0;
    reg_we_o     = '0;
    reg_re_o     = '0;
    reg_wd_o     = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          state_d   = ACCESS;
          // Grant is combinational, so hold it low while reset is asserted.
          bus.gnt_o = rst_ni ? arb_gnt : 2'b00;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!dec_err) begin
          if (we_q) begin
            reg_we_o = idx_oh;
            reg_wd_o = wdata_q;
          end else begin
            reg_re_o = idx_oh;
          end
        end
      end
      RESP: begin
        state_d               = IDLE;
        bus.rvalid_o[owner_q] = 1'b1;
        bus.rdata_o           = rdata_q;
        bus.err_o             = err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && |arb_gnt) begin
        owner_q <= arb_gnt[1];
        last_q  <= arb_gnt[1];
        addr_q  <= bus.addr_i[arb_gnt[1]];
        we_q    <= bus.we_i[arb_gnt[1]];
        wdata_q <= bus.wdata_i[arb_gnt[1]];
      end
      // Sampled in the pulse cycle so read-to-clear registers return their pre-clear value.
      if (state_q == ACCESS) begin
        rdata_q <= (!we_q && !dec_err) ? qs_sel : '0;
        err_q   <= dec_err;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed vector table, corner-case sequences and a randomized run against a transaction-level model.
module tb_reg_bank_arbiter;
  import reg_arb_pkg::*;

  localparam int unsigned NREGS = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  reg_bank_arbiter_if #(.DW(DW), .AW(AW)) bus ();
  logic [NREGS-1:0]         reg_we_o, reg_re_o;
  logic [DW-1:0]            reg_wd_o;
  logic [NREGS-1:0][DW-1:0] reg_qs_i;

  reg_bank_arbiter #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .bus      (bus),
    .reg_we_o (reg_we_o),
    .reg_re_o (reg_re_o),
    .reg_wd_o (reg_wd_o),
    .reg_qs_i (reg_qs_i)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             id;
    logic             we;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    int               qs_idx;
    logic [DW-1:0]    qs_val;
    logic [1:0]       e_gnt;
    logic [NREGS-1:0] e_we;
    logic [NREGS-1:0] e_re;
    logic [DW-1:0]    e_wd;
    logic [1:0]       e_rv;
    logic [DW-1:0]    e_rdata;
    logic             e_err;
  } vec_t;

  typedef struct {
    logic [1:0]       gnt;
    logic [NREGS-1:0] we;
    logic [NREGS-1:0] re;
    logic [DW-1:0]    wd;
    logic [1:0]       rv;
    logic [DW-1:0]    rdata;
    logic             err;
    logic             upd;
    int               upd_idx;
    logic [DW-1:0]    upd_val;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string t, input logic [1:0] g, input logic [NREGS-1:0] w,
                           input logic [NREGS-1:0] r, input logic [DW-1:0] wd,
                           input logic [1:0] rv, input logic [DW-1:0] rd, input logic e);
    chk({t, " gnt"},    32'(bus.gnt_o),    32'(g));
    chk({t, " reg_we"}, 32'(reg_we_o),     32'(w));
    chk({t, " reg_re"}, 32'(reg_re_o),     32'(r));
    chk({t, " reg_wd"}, reg_wd_o,          wd);
    chk({t, " rvalid"}, 32'(bus.rvalid_o), 32'(rv));
    chk({t, " rdata"},  bus.rdata_o,       rd);
    chk({t, " err"},    32'(bus.err_o),    32'(e));
  endtask

  task automatic idle_inputs();
    bus.req_i   = '0;
    bus.addr_i  = '0;
    bus.we_i    = '0;
    bus.wdata_i = '0;
  endtask

  task automatic fill_qs();
    for (int k = 0; k < int'(NREGS); k++) reg_qs_i[k] = 32'hC0DE_0000 + k;
  endtask

  // Reset with both requests raised: every output, including the grant, must stay 0.
  task automatic do_reset(input logic keep_req);
    rst_ni = 1'b0;
    idle_inputs();
    bus.req_i = 2'b11;
    #1;
    check_all("reset", 2'b00, '0, '0, '0, 2'b00, '0, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    if (!keep_req) bus.req_i = 2'b00;
    rst_ni = 1'b1;
  endtask

  task automatic run_vec(input string t, input vec_t v);
    @(posedge clk_i); #1;
    fill_qs();
    reg_qs_i[v.qs_idx]  = v.qs_val;
    bus.req_i           = '0;
    bus.req_i[v.id]     = 1'b1;
    bus.addr_i[v.id]    = v.addr;
    bus.we_i[v.id]      = v.we;
    bus.wdata_i[v.id]   = v.wdata;
    @(negedge clk_i);
    check_all({t, " grant"}, v.e_gnt, '0, '0, '0, 2'b00, '0, 1'b0);
    @(posedge clk_i); #1;
    bus.req_i = '0;
    @(negedge clk_i);
    check_all({t, " access"}, 2'b00, v.e_we, v.e_re, v.e_wd, 2'b00, '0, 1'b0);
    @(negedge clk_i);
    check_all({t, " resp"}, 2'b00, '0, '0, '0, v.e_rv, v.e_rdata, v.e_err);
  endtask

  // Register 7 behaves as read-to-clear: cleared just after the pulse edge.
  task automatic rc_read(input string t, input logic [DW-1:0] exp_rd);
    @(posedge clk_i); #1;
    bus.req_i     = 2'b01;
    bus.addr_i[0] = 6'h1C;
    bus.we_i[0]   = 1'b0;
    @(negedge clk_i);
    chk({t, " gnt"}, 32'(bus.gnt_o), 32'h1);
    @(posedge clk_i); #1;
    bus.req_i = '0;
    @(negedge clk_i);
    chk({t, " reg_re"}, 32'(reg_re_o), 32'h80);
    @(posedge clk_i); #1;
    reg_qs_i[7] = '0;
    @(negedge clk_i);
    chk({t, " rvalid"}, 32'(bus.rvalid_o), 32'h1);
    chk({t, " rdata"}, bus.rdata_o, exp_rd);
  endtask

  vec_t vecs[7];
  exp_t q[$];
  logic [NREGS-1:0][DW-1:0] mem;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //            id   we    addr   wdata         qs_idx qs_val        gnt    we     re     wd            rv     rdata         err
    vecs[0] = '{1'b0, 1'b1, 6'h08, 32'hDEADBEEF, 0, 32'h0000_0000, 2'b01, 8'h04, 8'h00, 32'hDEADBEEF, 2'b01, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 6'h0C, 32'h0000_0000, 3, 32'h12345678, 2'b10, 8'h00, 8'h08, 32'h0000_0000, 2'b10, 32'h12345678, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 6'h20, 32'h0000_0000, 0, 32'h0000_0000, 2'b01, 8'h00, 8'h00, 32'h0000_0000, 2'b01, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 6'h05, 32'h0000_0000, 1, 32'h1111_1111, 2'b01, 8'h00, 8'h00, 32'h0000_0000, 2'b01, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 6'h1C, 32'h0BADF00D, 0, 32'h0000_0000, 2'b10, 8'h80, 8'h00, 32'h0BADF00D, 2'b10, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 6'h3E, 32'h7777_7777, 0, 32'h0000_0000, 2'b10, 8'h00, 8'h00, 32'h0000_0000, 2'b10, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 6'h00, 32'h0000_0000, 0, 32'hFFFF_0001, 2'b01, 8'h00, 8'h01, 32'h0000_0000, 2'b01, 32'hFFFF_0001, 1'b0};

    fill_qs();
    do_reset(1'b0);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Read-to-clear: first read returns the pre-clear value, second read returns 0.
    reg_qs_i[7] = 32'hA5A5_0F0F;
    rc_read("rc1", 32'hA5A5_0F0F);
    rc_read("rc2", 32'h0);

    // Reset in the pulse cycle aborts the access with no later response.
    @(posedge clk_i); #1;
    bus.req_i = 2'b01; bus.addr_i[0] = 6'h08; bus.we_i[0] = 1'b1; bus.wdata_i[0] = 32'h5555_AAAA;
    @(posedge clk_i); #1;
    bus.req_i = 2'b00;
    chk("abort pre reg_we", 32'(reg_we_o), 32'h04);
    #2 rst_ni = 1'b0;
    #1 check_all("abort in reset", 2'b00, '0, '0, '0, 2'b00, '0, 1'b0);
    @(posedge clk_i); #3 rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check_all($sformatf("abort after%0d", k), 2'b00, '0, '0, '0, 2'b00, '0, 1'b0);
    end
    run_vec("post abort", '{1'b1, 1'b0, 6'h0C, 32'h0, 3, 32'h0246_8ACE, 2'b10, 8'h00, 8'h08, 32'h0, 2'b10, 32'h0246_8ACE, 1'b0});

    // Both requesting continuously from reset: grants alternate starting with requester 0.
    fill_qs();
    do_reset(1'b1);
    #2;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk_i);
      chk($sformatf("alt gnt c%0d", k), 32'(bus.gnt_o),
          (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      chk($sformatf("alt rvalid c%0d", k), 32'(bus.rvalid_o),
          (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
    end
    @(posedge clk_i); #1;
    bus.req_i = 2'b00;

    // Randomized traffic against a transaction-level model of the arbiter and register bank.
    do_reset(1'b0);
    begin
      logic last;
      last = 1'b1;
      for (int k = 0; k < int'(NREGS); k++) mem[k] = $urandom;
      for (int cyc = 0; cyc < 600; cyc++) begin
        exp_t e;
        @(posedge clk_i); #1;
        for (int r = 0; r < 2; r++) begin
          int sel, a;
          sel = $urandom_range(0, 9);
          if (sel < 8) a = sel * 4;
          else if (sel == 8) a = (8 + $urandom_range(0, 7)) * 4;
          else begin
            a = $urandom_range(0, 63);
            if (a % 4 == 0) a = a + 1;
          end
          bus.req_i[r]   = 1'($urandom_range(0, 1));
          bus.addr_i[r]  = AW'(a);
          bus.we_i[r]    = 1'($urandom_range(0, 1));
          bus.wdata_i[r] = $urandom;
        end
        reg_qs_i = mem;
        @(negedge clk_i);
        e = '{default: '0};
        if (q.size() == 0) begin
          if (bus.req_i != 2'b00) begin
            logic          id;
            logic [AW-1:0] ad;
            int            idx;
            logic          bad;
            exp_t          acc, rsp;
            id    = (bus.req_i == 2'b11) ? ~last : bus.req_i[1];
            last  = id;
            e.gnt = id ? 2'b10 : 2'b01;
            ad    = bus.addr_i[id];
            idx   = int'(ad) / 4;
            bad   = (int'(ad) % 4 != 0) || (idx >= int'(NREGS));
            acc   = '{default: '0};
            rsp   = '{default: '0};
            rsp.rv  = id ? 2'b10 : 2'b01;
            rsp.err = bad;
            if (!bad) begin
              if (bus.we_i[id]) begin
                acc.we[idx] = 1'b1;
                acc.wd      = bus.wdata_i[id];
                acc.upd     = 1'b1;
                acc.upd_idx = idx;
                acc.upd_val = bus.wdata_i[id];
              end else begin
                acc.re[idx] = 1'b1;
                rsp.rdata   = mem[idx];
                if (idx == 7) begin
                  acc.upd     = 1'b1;
                  acc.upd_idx = 7;
                  acc.upd_val = '0;
                end
              end
            end
            q.push_back(acc);
            q.push_back(rsp);
          end
        end else begin
          e = q.pop_front();
        end
        check_all($sformatf("rnd c%0d", cyc), e.gnt, e.we, e.re, e.wd, e.rv, e.rdata, e.err);
        if (e.upd) mem[e.upd_idx] = e.upd_val;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
